kernel_addr_seq: RTL and testbench

Descriptor-driven, parametrised kernel-weight read-address sequencer for the ShuffleNet memory-control path. It replaces hard-coded per-stage offset and row-size tables with a configuration handshake, so a controller can load any layer shape. Once loaded, it streams kernel-ROM addresses under a valid/ready handshake, with abort. It also drives per-lane kernel-select codes to the convolution lanes, delayed to line up with ROM read latency.

---
 rtl/kernel_addr_seq.sv | 231 +++++++++++++++++++++++
 tb/tb_kernel_addr_seq.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/kernel_addr_seq.sv
// kernel_addr_seq
// Descriptor-driven kernel-weight read-address sequencer. A controller loads a
// layer descriptor (offset, words per kernel, kernels per pass, pass count,
// lane mode). The block then streams kernel-ROM addresses under a valid/ready
// handshake, and an abort input can end the run early. Per-lane kernel-select
// codes follow each accepted address SEL_DELAY cycles later, so they line up
// with the ROM read latency.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   cfg_valid/ready   descriptor handshake (ready only in IDLE)
//   cfg_offset        base address of the layer's kernels
//   cfg_row_size      words per kernel
//   cfg_kernels       kernels per pass
//   cfg_repeat        passes over the kernel set
//   cfg_broadcast     0 = lane i gets code i, 1 = all lanes get the pass index
//   abort             terminate the current run (RUN only)
//   addr_valid/ready  address beat handshake
//   read_kernel_addr  kernel-ROM address
//   kernel_select     lane i code at bits [i*SEL_W +: SEL_W]
//   select_valid      kernel_select belongs to a beat SEL_DELAY cycles earlier
//   busy              sequencer not idle
//   done              one-cycle pulse at normal completion
module kernel_addr_seq #(
  parameter int ADDR_W    = 9,
  parameter int LANES     = 4,
  parameter int ROW_W     = 5,
  parameter int KCNT_W    = 5,
  parameter int SEL_DELAY = 2,
  localparam int SEL_W    = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [ADDR_W-1:0]        cfg_offset,
  input  logic [ROW_W-1:0]         cfg_row_size,
  input  logic [KCNT_W-1:0]        cfg_kernels,
  input  logic [KCNT_W-1:0]        cfg_repeat,
  input  logic                     cfg_broadcast,
  input  logic                     abort,
  output logic                     addr_valid,
  input  logic                     addr_ready,
  output logic [ADDR_W-1:0]        read_kernel_addr,
  output logic [LANES*SEL_W-1:0]   kernel_select,
  output logic                     select_valid,
  output logic                     busy,
  output logic                     done
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int CODE_W = LANES * SEL_W;

  // Lane codes for one beat: lane index in distinct mode, pass index in broadcast mode.
  function automatic logic [CODE_W-1:0] lane_codes(input logic bcast, input logic [KCNT_W-1:0] pass);
    logic [CODE_W-1:0] v;
    v = {CODE_W{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      if (bcast) begin
        v[i*SEL_W +: SEL_W] = SEL_W'(32'(pass) % LANES);
      end else begin
        v[i*SEL_W +: SEL_W] = SEL_W'(i % LANES);
      end
    end
    return v;
  endfunction

  logic [1:0]        state_r, state_nx_s;
  logic [ADDR_W-1:0] offset_r;
  logic [ROW_W-1:0]  row_r;
  logic [KCNT_W-1:0] kern_r;
  logic [KCNT_W-1:0] rep_r;
  logic              bcast_r;

  logic [ROW_W-1:0]  r_r, r_nx_s;
  logic [KCNT_W-1:0] k_r, k_nx_s;
  logic [KCNT_W-1:0] p_r, p_nx_s;
  logic [ADDR_W-1:0] base_r, base_nx_s;
  logic [ADDR_W-1:0] addr_r, addr_nx_s;

  logic cfg_ready_r, addr_valid_r, busy_r, done_r;

  logic [CODE_W-1:0] sel_pipe_r  [SEL_DELAY];
  logic              flag_pipe_r [SEL_DELAY];
  logic [CODE_W-1:0] code_s;

  logic accept_s, beat_s, zero_cfg_s;
  logic row_last_s, kern_last_s, pass_last_s;

  // Handshake qualifiers and end-of-row/kernel/pass detection.
  always_comb begin
    accept_s    = (state_r == ST_IDLE) && cfg_valid;
    // An abort swallows the pending beat, so it never counts as a completed beat.
    beat_s      = (state_r == ST_RUN) && addr_ready && !abort;
    zero_cfg_s  = (cfg_row_size == {ROW_W{1'b0}}) || (cfg_kernels == {KCNT_W{1'b0}}) ||
                  (cfg_repeat == {KCNT_W{1'b0}});
    row_last_s  = (r_r == (row_r - ROW_W'(1)));
    kern_last_s = (k_r == (kern_r - KCNT_W'(1)));
    pass_last_s = (p_r == (rep_r - KCNT_W'(1)));
    code_s      = lane_codes(bcast_r, p_r);
  end

  // Next-state decode.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nx_s = zero_cfg_s ? ST_DONE : ST_RUN;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_nx_s = ST_IDLE;
        end else if (beat_s && row_last_s && kern_last_s && pass_last_s) begin
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_RUN;
        end
      end
      ST_DONE: state_nx_s = ST_IDLE;
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Row/kernel/pass counters and the running kernel base address.
  always_comb begin
    r_nx_s    = r_r;
    k_nx_s    = k_r;
    p_nx_s    = p_r;
    base_nx_s = base_r;
    if (accept_s) begin
      r_nx_s    = {ROW_W{1'b0}};
      k_nx_s    = {KCNT_W{1'b0}};
      p_nx_s    = {KCNT_W{1'b0}};
      base_nx_s = cfg_offset;
    end else if (beat_s) begin
      if (row_last_s) begin
        r_nx_s = {ROW_W{1'b0}};
        if (kern_last_s) begin
          k_nx_s    = {KCNT_W{1'b0}};
          p_nx_s    = p_r + KCNT_W'(1);
          base_nx_s = offset_r;
        end else begin
          k_nx_s    = k_r + KCNT_W'(1);
          p_nx_s    = p_r;
          base_nx_s = base_r + ADDR_W'(row_r);
        end
      end else begin
        r_nx_s = r_r + ROW_W'(1);
      end
    end else begin
      r_nx_s = r_r;
    end
    // Address arithmetic wraps modulo 2^ADDR_W by truncation.
    addr_nx_s = base_nx_s + ADDR_W'(r_nx_s);
  end

  // State, descriptor, counters and registered handshake/status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      offset_r     <= {ADDR_W{1'b0}};
      row_r        <= {ROW_W{1'b0}};
      kern_r       <= {KCNT_W{1'b0}};
      rep_r        <= {KCNT_W{1'b0}};
      bcast_r      <= 1'b0;
      r_r          <= {ROW_W{1'b0}};
      k_r          <= {KCNT_W{1'b0}};
      p_r          <= {KCNT_W{1'b0}};
      base_r       <= {ADDR_W{1'b0}};
      addr_r       <= {ADDR_W{1'b0}};
      cfg_ready_r  <= 1'b1;
      addr_valid_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      if (accept_s) begin
        offset_r <= cfg_offset;
        row_r    <= cfg_row_size;
        kern_r   <= cfg_kernels;
        rep_r    <= cfg_repeat;
        bcast_r  <= cfg_broadcast;
      end else begin
        offset_r <= offset_r;
      end
      r_r          <= r_nx_s;
      k_r          <= k_nx_s;
      p_r          <= p_nx_s;
      base_r       <= base_nx_s;
      addr_r       <= addr_nx_s;
      // Status outputs are registered copies of the next-state decode.
      cfg_ready_r  <= (state_nx_s == ST_IDLE);
      addr_valid_r <= (state_nx_s == ST_RUN);
      busy_r       <= (state_nx_s != ST_IDLE);
      done_r       <= (state_nx_s == ST_DONE);
    end
  end

  // Select delay line: shifts every clock; idle cycles insert a zero flag and hold the code.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SEL_DELAY; i++) begin
        sel_pipe_r[i]  <= {CODE_W{1'b0}};
        flag_pipe_r[i] <= 1'b0;
      end
    end else begin
      sel_pipe_r[0]  <= beat_s ? code_s : sel_pipe_r[0];
      flag_pipe_r[0] <= beat_s;
      for (int i = 1; i < SEL_DELAY; i++) begin
        sel_pipe_r[i]  <= sel_pipe_r[i-1];
        flag_pipe_r[i] <= flag_pipe_r[i-1];
      end
    end
  end

  assign cfg_ready        = cfg_ready_r;
  assign addr_valid       = addr_valid_r;
  assign busy             = busy_r;
  assign done             = done_r;
  assign read_kernel_addr = addr_r;
  assign kernel_select    = sel_pipe_r[SEL_DELAY-1];
  assign select_valid     = flag_pipe_r[SEL_DELAY-1];

endmodule

// File: tb/tb_kernel_addr_seq.sv
// Self-checking bench for kernel_addr_seq: directed descriptors from the test
// plan plus random descriptors with random backpressure, compared against a
// loop-nest reference model of the address and lane-code stream.
module tb_kernel_addr_seq;

  localparam int ADDR_W    = 9;
  localparam int LANES     = 4;
  localparam int ROW_W     = 5;
  localparam int KCNT_W    = 5;
  localparam int SEL_DELAY = 2;
  localparam int SEL_W     = 2;
  localparam int CODE_W    = LANES * SEL_W;

  logic               clk;
  logic               reset;
  logic               cfg_valid;
  logic               cfg_ready;
  logic [ADDR_W-1:0]  cfg_offset;
  logic [ROW_W-1:0]   cfg_row_size;
  logic [KCNT_W-1:0]  cfg_kernels;
  logic [KCNT_W-1:0]  cfg_repeat;
  logic               cfg_broadcast;
  logic               abort;
  logic               addr_valid;
  logic               addr_ready;
  logic [ADDR_W-1:0]  read_kernel_addr;
  logic [CODE_W-1:0]  kernel_select;
  logic               select_valid;
  logic               busy;
  logic               done;

  kernel_addr_seq #(
    .ADDR_W(ADDR_W), .LANES(LANES), .ROW_W(ROW_W), .KCNT_W(KCNT_W), .SEL_DELAY(SEL_DELAY)
  ) dut (
    .clk(clk), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_offset(cfg_offset), .cfg_row_size(cfg_row_size),
    .cfg_kernels(cfg_kernels), .cfg_repeat(cfg_repeat), .cfg_broadcast(cfg_broadcast),
    .abort(abort), .addr_valid(addr_valid), .addr_ready(addr_ready),
    .read_kernel_addr(read_kernel_addr), .kernel_select(kernel_select),
    .select_valid(select_valid), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int sel_seen = 0;

  // Expected select stream indexed by cycle number.
  bit              exp_flag [8192];
  bit [CODE_W-1:0] exp_code [8192];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Advance one clock and check the select pipe output against the schedule.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    check("sel_valid", 32'(select_valid), 32'(exp_flag[cyc]));
    if (exp_flag[cyc]) check("sel_code", 32'(kernel_select), 32'(exp_code[cyc]));
    if (select_valid) sel_seen++;
  endtask

  function automatic bit [CODE_W-1:0] model_codes(input bit bc, input int pass);
    bit [CODE_W-1:0] v;
    v = '0;
    for (int i = 0; i < LANES; i++) begin
      if (bc) v[i*SEL_W +: SEL_W] = SEL_W'(pass % LANES);
      else    v[i*SEL_W +: SEL_W] = SEL_W'(i);
    end
    return v;
  endfunction

  // Run one descriptor. ready_mode 0: addr_ready held 1, 1: random.
  // abort_at / reset_at: number of completed beats at which to abort / reset (-1 = never).
  task automatic run_desc(input int off, input int row, input int kern, input int rep,
                          input bit bc, input int ready_mode, input int abort_at, input int reset_at);
    bit [ADDR_W-1:0] addr_q[$];
    bit [CODE_W-1:0] code_q[$];
    int w;
    int beats;
    int budget;
    bit rdy;
    for (int p = 0; p < rep; p++)
      for (int k = 0; k < kern; k++)
        for (int r = 0; r < row; r++) begin
          addr_q.push_back(ADDR_W'(off + k * row + r));
          code_q.push_back(model_codes(bc, p));
        end
    w = 0;
    while (!cfg_ready && w < 20) begin
      tick();
      w++;
    end
    check("cfg_ready_wait", 32'(cfg_ready), 32'd1);
    cfg_valid     = 1'b1;
    cfg_offset    = ADDR_W'(off);
    cfg_row_size  = ROW_W'(row);
    cfg_kernels   = KCNT_W'(kern);
    cfg_repeat    = KCNT_W'(rep);
    cfg_broadcast = bc;
    tick();
    cfg_valid = 1'b0;
    // Fields change after accept; the run must not notice.
    cfg_offset    = ADDR_W'($urandom);
    cfg_row_size  = ROW_W'($urandom);
    cfg_kernels   = KCNT_W'($urandom);
    cfg_repeat    = KCNT_W'($urandom);
    cfg_broadcast = 1'($urandom);
    if (addr_q.size() == 0) begin
      check("zero_done", 32'(done), 32'd1);
      check("zero_addr_valid", 32'(addr_valid), 32'd0);
      check("zero_cfg_ready", 32'(cfg_ready), 32'd0);
      tick();
      check("zero_done_end", 32'(done), 32'd0);
      check("zero_idle", 32'(cfg_ready), 32'd1);
      return;
    end
    beats = 0;
    budget = 0;
    while (addr_q.size() > 0 && budget < 2000) begin
      budget++;
      check("addr_valid", 32'(addr_valid), 32'd1);
      check("addr", 32'(read_kernel_addr), 32'(addr_q[0]));
      check("busy_run", 32'(busy), 32'd1);
      check("cfg_ready_run", 32'(cfg_ready), 32'd0);
      check("done_run", 32'(done), 32'd0);
      if (beats == abort_at) begin
        addr_ready = 1'b1;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        addr_ready = 1'b0;
        check("abort_addr_valid", 32'(addr_valid), 32'd0);
        check("abort_cfg_ready", 32'(cfg_ready), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        tick();
        check("abort_done2", 32'(done), 32'd0);
        check("abort_idle", 32'(cfg_ready), 32'd1);
        return;
      end
      if (beats == reset_at) begin
        addr_ready = 1'b1;
        reset = 1'b1;
        for (int i = cyc + 1; i <= cyc + SEL_DELAY + 1; i++) exp_flag[i] = 1'b0;
        tick();
        reset = 1'b0;
        addr_ready = 1'b0;
        check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        check("rst_addr_valid", 32'(addr_valid), 32'd0);
        check("rst_addr", 32'(read_kernel_addr), 32'd0);
        check("rst_ksel", 32'(kernel_select), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        return;
      end
      rdy = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      addr_ready = rdy;
      if (rdy) begin
        exp_flag[cyc + SEL_DELAY] = 1'b1;
        exp_code[cyc + SEL_DELAY] = code_q[0];
        void'(addr_q.pop_front());
        void'(code_q.pop_front());
        beats++;
      end
      tick();
    end
    addr_ready = 1'b0;
    check("run_budget", 32'(addr_q.size()), 32'd0);
    check("done_pulse", 32'(done), 32'd1);
    check("done_cfg_ready", 32'(cfg_ready), 32'd0);
    check("done_addr_valid", 32'(addr_valid), 32'd0);
    tick();
    check("done_end", 32'(done), 32'd0);
    check("idle_cfg_ready", 32'(cfg_ready), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int snap;
    reset = 1'b1;
    cfg_valid = 1'b0;
    cfg_offset = '0;
    cfg_row_size = '0;
    cfg_kernels = '0;
    cfg_repeat = '0;
    cfg_broadcast = 1'b0;
    abort = 1'b0;
    addr_ready = 1'b0;
    tick();
    tick();
    check("reset_cfg_ready", 32'(cfg_ready), 32'd1);
    check("reset_addr_valid", 32'(addr_valid), 32'd0);
    check("reset_addr", 32'(read_kernel_addr), 32'd0);
    check("reset_ksel", 32'(kernel_select), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    reset = 1'b0;
    tick();

    // Abort in IDLE is ignored.
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("idle_abort", 32'(cfg_ready), 32'd1);

    run_desc(8, 4, 1, 1, 1'b0, 0, -1, -1);      // single kernel, distinct
    run_desc(0, 2, 4, 4, 1'b1, 0, -1, -1);      // broadcast, multi-pass
    snap = sel_seen;
    run_desc(236, 8, 2, 1, 1'b0, 1, -1, -1);    // backpressure
    for (int i = 0; i < SEL_DELAY; i++) tick();
    check("bp_sel_count", 32'(sel_seen - snap), 32'd16);
    run_desc(508, 8, 1, 1, 1'b0, 0, -1, -1);    // address wrap
    run_desc(5, 3, 0, 2, 1'b0, 0, -1, -1);      // zero kernels
    run_desc(5, 0, 2, 2, 1'b1, 0, -1, -1);      // zero row size
    run_desc(100, 8, 2, 1, 1'b0, 0, 4, -1);     // abort on beat 5 of 16
    run_desc(40, 3, 2, 2, 1'b1, 1, -1, -1);     // clean after abort
    run_desc(200, 4, 3, 2, 1'b0, 0, -1, 7);     // reset mid-run
    run_desc(12, 2, 2, 1, 1'b1, 0, -1, -1);     // clean after reset
    run_desc(60, 2, 2, 2, 1'b0, 0, 7, -1);      // abort on the final beat
    run_desc(70, 3, 1, 2, 1'b1, 0, -1, -1);     // back-to-back pair
    run_desc(90, 2, 2, 1, 1'b0, 0, -1, -1);

    for (int t = 0; t < 12; t++) begin
      run_desc(int'($urandom_range(0, 511)), int'($urandom_range(1, 6)),
               int'($urandom_range(1, 4)), int'($urandom_range(1, 3)),
               1'($urandom_range(0, 1)), int'($urandom_range(0, 1)), -1, -1);
    end
    for (int i = 0; i < SEL_DELAY + 1; i++) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
